// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: default widths and the FSM state type.
package scan_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int NUM_CH_DEF  = 2 ** SEL_W_DEF;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Circular next-set-bit search over a channel mask.
// Returns the first enabled channel strictly after idx_i (wrapping past the top),
// and flags when that channel is at or below idx_i. With idx_i at the highest
// channel the result is the lowest set bit. An empty mask returns idx_i.
module scan_next_ch #(
  parameter int SEL_W = 3
) (
  input  logic [2**SEL_W-1:0] mask_i,
  input  logic [SEL_W-1:0]    idx_i,
  output logic [SEL_W-1:0]    nxt_o,
  output logic                wrapped_o
);

  localparam int NUM_CH = 2 ** SEL_W;

  logic             found;
  logic [SEL_W-1:0] cand;

  // Walk candidates idx+1 .. idx+NUM_CH modulo NUM_CH, keeping the first enabled one
  always_comb begin
    nxt_o = idx_i;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = idx_i + SEL_W'(k);
      if (!found && mask_i[cand]) begin
        nxt_o = cand;
        found = 1'b1;
      end
    end
    wrapped_o = (nxt_o <= idx_i);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: walks the enabled channels of a latched mask in
// ascending circular order, presenting each for an effective dwell of
// max(dwell,1) cycles, in single-shot or continuous mode.
// Optional feature macro: SCAN_PAUSE_EN adds a 'pause' input that freezes the
// scan in place while asserted.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
`ifdef SCAN_PAUSE_EN
  input  logic                pause,
`endif
  input  logic                continuous,
  input  logic [2**SEL_W-1:0] ch_mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_valid,
  output logic                busy,
  output logic                done,
  output logic                wrap
);

  localparam int NUM_CH = 2 ** SEL_W;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                cont_q, cont_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;

  logic [NUM_CH-1:0]   srchMask;
  logic [SEL_W-1:0]    srchIdx;
  logic [SEL_W-1:0]    nxtCh;
  logic                nxtWrapped;
  logic                pauseActive;
  logic [DWELL_W-1:0]  startLoad;
  logic [DWELL_W-1:0]  reloadCnt;

`ifdef SCAN_PAUSE_EN
  assign pauseActive = pause;
`else
  assign pauseActive = 1'b0;
`endif

  // Counter preload is eff_dwell-1, where a zero dwell behaves as one cycle
  assign startLoad = (dwell == '0)   ? '0 : dwell   - DWELL_W'(1);
  assign reloadCnt = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  // One search unit is shared: in IDLE it finds the lowest set bit of the live
  // mask (search from the top index), in SCAN it finds the successor of sel
  always_comb begin
    if (state_q == SCAN) begin
      srchMask = mask_q;
      srchIdx  = sel_q;
    end else begin
      srchMask = ch_mask;
      srchIdx  = SEL_W'(NUM_CH - 1);
    end
  end

  scan_next_ch #(
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask_i    (srchMask),
    .idx_i     (srchIdx),
    .nxt_o     (nxtCh),
    .wrapped_o (nxtWrapped)
  );

  // Next-state logic: start/latch in IDLE, dwell countdown and channel advance in SCAN
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (ch_mask != '0) begin
            mask_d  = ch_mask;
            dwell_d = dwell;
            cont_d  = continuous;
            sel_d   = nxtCh;
            cnt_d   = startLoad;
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pauseActive) begin
          state_d = SCAN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxtWrapped) begin
          wrap_d = 1'b1;
          if (cont_q) begin
            sel_d = nxtCh;
            cnt_d = reloadCnt;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          sel_d = nxtCh;
          cnt_d = reloadCnt;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios followed by a
// randomized run, all compared every cycle against a channel-list model.
// Build with SCAN_PAUSE_EN defined to also exercise the pause input.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       continuous;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       wrap;

  int compCount = 0;
  int errCount  = 0;

  // Model: the list of enabled channels for the current scan, a position in it,
  // and how many presentation cycles remain on the current channel
  bit         mActive = 1'b0;
  int         chans[$];
  int         mPos  = 0;
  int         mLeft = 0;
  int         mEff  = 1;
  bit         mCont = 1'b0;
  logic [2:0] mSel  = 3'd0;
  bit         mDone = 1'b0;
  bit         mWrap = 1'b0;

  always #5 clk = ~clk;

  scan_sequencer #(
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef SCAN_PAUSE_EN
    .pause      (pause),
`endif
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge
  task automatic modelStep();
    bit pz;
    pz = 1'b0;
`ifdef SCAN_PAUSE_EN
    pz = pause;
`endif
    mDone = 1'b0;
    mWrap = 1'b0;
    if (rst) begin
      mActive = 1'b0;
      mSel    = 3'd0;
      chans.delete();
    end else if (!mActive) begin
      if (start && !stop) begin
        if (ch_mask == 8'd0) begin
          mDone = 1'b1;
        end else begin
          chans.delete();
          for (int c = 0; c < 8; c++) if (ch_mask[c]) chans.push_back(c);
          mPos    = 0;
          mEff    = (dwell == 8'd0) ? 1 : int'(dwell);
          mLeft   = mEff;
          mCont   = continuous;
          mActive = 1'b1;
          mSel    = 3'(chans[0]);
        end
      end
    end else if (stop) begin
      mActive = 1'b0;
    end else if (!pz) begin
      mLeft--;
      if (mLeft == 0) begin
        mPos++;
        mLeft = mEff;
        if (mPos == chans.size()) begin
          mWrap = 1'b1;
          mPos  = 0;
          if (!mCont) begin
            mActive = 1'b0;
            mDone   = 1'b1;
          end
        end
        if (mActive) mSel = 3'(chans[mPos]);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".sel"},       32'(sel),       32'(mSel));
    chk({tag, ".sel_valid"}, 32'(sel_valid), 32'(mActive));
    chk({tag, ".busy"},      32'(busy),      32'(mActive));
    chk({tag, ".done"},      32'(done),      32'(mDone));
    chk({tag, ".wrap"},      32'(wrap),      32'(mWrap));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic c, input logic [7:0] m, input logic [7:0] d);
    rst        = r;
    start      = s;
    stop       = p;
    continuous = c;
    ch_mask    = m;
    dwell      = d;
  endtask

  initial begin
    int seq1[8];
    int exp1[8];
    int selCount;
    exp1 = '{0, 0, 2, 2, 5, 5, 7, 7};
    pause = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;

    $display("[TB] reset");
    tick("reset");
    tick("reset");
    chk("reset.sel", 32'(sel), 0);
    chk("reset.valid", 32'(sel_valid), 0);

    $display("[TB] single-shot mask A5 dwell 2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'd2);
    for (int i = 0; i < 8; i++) begin
      tick("t1");
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
      seq1[i] = int'(sel);
      chk("t1.valid", 32'(sel_valid), 1);
    end
    for (int i = 0; i < 8; i++) chk("t1.seq", 32'(seq1[i]), 32'(exp1[i]));
    tick("t1end");
    chk("t1.done", 32'(done), 1);
    chk("t1.wrap", 32'(wrap), 1);
    chk("t1.idle", 32'(busy), 0);
    tick("t1idle");
    chk("t1.done_once", 32'(done), 0);

    $display("[TB] empty mask");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3);
    tick("t2");
    chk("t2.done", 32'(done), 1);
    chk("t2.valid", 32'(sel_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
    tick("t2b");
    chk("t2.done_once", 32'(done), 0);

    $display("[TB] single channel continuous dwell 0");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'd0);
    tick("t3");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
    chk("t3.sel", 32'(sel), 4);
    for (int i = 0; i < 5; i++) begin
      tick("t3run");
      chk("t3.wrap", 32'(wrap), 1);
      chk("t3.nodone", 32'(done), 0);
      chk("t3.sel_hold", 32'(sel), 4);
    end
    stop = 1'b1;
    tick("t3stop");
    stop = 1'b0;
    chk("t3.stop_valid", 32'(sel_valid), 0);
    chk("t3.stop_done", 32'(done), 0);
    tick("t3idle");

    $display("[TB] full mask continuous, inputs changed mid-scan");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd3);
    tick("t4");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'd1);
    tick("t4chg");
    start = 1'b0;
    for (int i = 0; i < 26; i++) tick("t4run");
    chk("t4.sel_after", 32'(sel), 1);
    stop = 1'b1;
    tick("t4stop");
    stop = 1'b0;

    $display("[TB] stop on final expiry");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'd1);
    tick("t5");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
    tick("t5stop");
    chk("t5.done", 32'(done), 0);
    chk("t5.wrap", 32'(wrap), 0);
    chk("t5.idle", 32'(busy), 0);
    stop = 1'b0;
    tick("t5idle");

    $display("[TB] reset mid-scan");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'd4);
    tick("t6");
    start = 1'b0;
    tick("t6run");
    chk("t6.sel3", 32'(sel), 3);
    rst = 1'b1;
    tick("t6rst");
    chk("t6.rst_sel", 32'(sel), 0);
    chk("t6.rst_valid", 32'(sel_valid), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 8'd1);
    tick("t6restart");
    start = 1'b0;
    chk("t6.restart_sel", 32'(sel), 1);
    tick("t6b");
    tick("t6c");
    chk("t6.restart_done", 32'(done), 1);
    tick("t6idle");

`ifdef SCAN_PAUSE_EN
    $display("[TB] pause on channel 2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'd2);
    selCount = 0;
    tick("t7");
    start = 1'b0;
    tick("t7");
    tick("t7");
    if (sel == 3'd2) selCount++;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t7pause");
      if (sel == 3'd2 && sel_valid) selCount++;
    end
    pause = 1'b0;
    tick("t7res");
    if (sel == 3'd2 && sel_valid) selCount++;
    chk("t7.hold_cycles", 32'(selCount), 7);
    tick("t7end");
    chk("t7.done", 32'(done), 1);
    tick("t7idle");
`else
    selCount = 0;
`endif

    $display("[TB] randomized run");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [7:0] m;
      case ($urandom_range(0, 7))
        0:       m = 8'h00;
        1:       m = 8'h01 << $urandom_range(0, 7);
        default: m = 8'($urandom);
      endcase
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 3) == 0);
      stop       = mActive ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 19) == 0);
      continuous = 1'($urandom);
      ch_mask    = m;
      dwell      = 8'($urandom_range(0, 4));
`ifdef SCAN_PAUSE_EN
      pause      = ($urandom_range(0, 5) == 0);
`endif
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
